// File: rtl/operand_regfile.sv
// Dual-bank (GPR/FPR) operand register file with registered reads, write-through bypass
// and the FP condition-code flag.
module operand_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic              ra_float,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              rb_float,
  output logic              rd_valid,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  input  logic              wr_en,
  input  logic              wr_float,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cc_we,
  input  logic              cc_in,
  output logic              fp_cc_q
);

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] fpr_q [NUM_REGS];
  logic [DATA_W-1:0] operand_a_q, operand_b_q;
  logic [DATA_W-1:0] operand_a_d, operand_b_d;
  logic              rd_valid_q;
  logic              cc_q;

  logic wr_ok;
  logic ra_ok, rb_ok;

  // GPR0 is hardwired zero; out-of-range indices are never stored or read.
  always_comb begin
    wr_ok = wr_en && (32'(wr_addr) < NUM_REGS) && !(!wr_float && (wr_addr == '0));
    ra_ok = (32'(ra_addr) < NUM_REGS) && !(!ra_float && (ra_addr == '0));
    rb_ok = (32'(rb_addr) < NUM_REGS) && !(!rb_float && (rb_addr == '0));
  end

  always_comb begin
    operand_a_d = '0;
    if (ra_ok) begin
      if (wr_ok && (wr_float == ra_float) && (wr_addr == ra_addr)) begin
        operand_a_d = wr_data;
      end else begin
        operand_a_d = ra_float ? fpr_q[ra_addr] : gpr_q[ra_addr];
      end
    end
  end

  always_comb begin
    operand_b_d = '0;
    if (rb_ok) begin
      if (wr_ok && (wr_float == rb_float) && (wr_addr == rb_addr)) begin
        operand_b_d = wr_data;
      end else begin
        operand_b_d = rb_float ? fpr_q[rb_addr] : gpr_q[rb_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        gpr_q[i] <= '0;
        fpr_q[i] <= '0;
      end
      cc_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      operand_a_q <= '0;
      operand_b_q <= '0;
    end else begin
      if (wr_ok) begin
        if (wr_float) begin
          fpr_q[wr_addr] <= wr_data;
        end else begin
          gpr_q[wr_addr] <= wr_data;
        end
      end
      if (cc_we) begin
        cc_q <= cc_in;
      end
      rd_valid_q <= rd_req;
      // Operands hold their last value when no read is requested.
      if (rd_req) begin
        operand_a_q <= operand_a_d;
        operand_b_q <= operand_b_d;
      end
    end
  end

  assign rd_valid  = rd_valid_q;
  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;
  assign fp_cc_q   = cc_q;

endmodule

// File: tb/tb_operand_regfile.sv
// Self-checking bench for operand_regfile: reference model plus a scoreboard of expected
// operand pairs pushed at request time and popped when the read completes.
module tb_operand_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [4:0]  ra_addr;
  logic        ra_float;
  logic [4:0]  rb_addr;
  logic        rb_float;
  logic        rd_valid;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        wr_en;
  logic        wr_float;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cc_we;
  logic        cc_in;
  logic        fp_cc_q;

  operand_regfile #(
    .DATA_W  (32),
    .NUM_REGS(32),
    .ADDR_W  (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .ra_addr  (ra_addr),
    .ra_float (ra_float),
    .rb_addr  (rb_addr),
    .rb_float (rb_float),
    .rd_valid (rd_valid),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .wr_en    (wr_en),
    .wr_float (wr_float),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cc_we    (cc_we),
    .cc_in    (cc_in),
    .fp_cc_q  (fp_cc_q)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] gpr_m [32];
  logic [31:0] fpr_m [32];
  logic        cc_m;
  logic [31:0] hold_a, hold_b;
  logic [63:0] sb [$];
  int          valid_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic f);
    if (!f && a == 5'd0) return 32'd0;
    if (wr_en && wr_float == f && wr_addr == a) begin
      if (f || wr_addr != 5'd0) return wr_data;
    end
    return f ? fpr_m[a] : gpr_m[a];
  endfunction

  task automatic idle();
    rst = 1'b0; rd_req = 1'b0; ra_addr = '0; ra_float = 1'b0; rb_addr = '0; rb_float = 1'b0;
    wr_en = 1'b0; wr_float = 1'b0; wr_addr = '0; wr_data = '0; cc_we = 1'b0; cc_in = 1'b0;
  endtask

  task automatic set_wr(input logic f, input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_float = f; wr_addr = a; wr_data = d;
  endtask

  task automatic set_rd(input logic af, input logic [4:0] a, input logic bf, input logic [4:0] b);
    rd_req = 1'b1; ra_float = af; ra_addr = a; rb_float = bf; rb_addr = b;
  endtask

  // One clock: predict, advance the model, then sample #1 after the edge.
  task automatic step();
    logic ev;
    logic was_rst;
    logic [63:0] ent;
    ev      = rd_req && !rst;
    was_rst = rst;
    if (ev) sb.push_back({m_read(ra_addr, ra_float), m_read(rb_addr, rb_float)});
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_m[i] = '0;
        fpr_m[i] = '0;
      end
      cc_m = 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_float) fpr_m[wr_addr] = wr_data;
        else if (wr_addr != 5'd0) gpr_m[wr_addr] = wr_data;
      end
      if (cc_we) cc_m = cc_in;
    end
    @(posedge clk);
    #1;
    check("rd_valid", {31'd0, rd_valid}, {31'd0, ev});
    valid_run = rd_valid ? valid_run + 1 : 0;
    if (was_rst) begin
      hold_a = '0;
      hold_b = '0;
    end
    if (ev) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        ent    = sb.pop_front();
        hold_a = ent[63:32];
        hold_b = ent[31:0];
      end
    end
    check("operand_a", operand_a, hold_a);
    check("operand_b", operand_b, hold_b);
    check("fp_cc_q", {31'd0, fp_cc_q}, {31'd0, cc_m});
    idle();
  endtask

  initial begin
    valid_run = 0;
    hold_a = '0;
    hold_b = '0;
    cc_m = 1'b0;
    for (int i = 0; i < 32; i++) begin
      gpr_m[i] = '0;
      fpr_m[i] = '0;
    end
    idle();
    rst = 1'b1; step();
    rst = 1'b1; step();

    // Reset contents read back as zero.
    set_rd(1'b0, 5'd5, 1'b1, 5'd5); step();
    step();

    // GPR3 vs FPR3 isolation.
    set_wr(1'b0, 5'd3, 32'h0000_00FF); step();
    set_rd(1'b0, 5'd3, 1'b1, 5'd3); step();
    check("gpr3", operand_a, 32'h0000_00FF);
    check("fpr3", operand_b, 32'h0);

    // GPR0 hardwired, FPR0 ordinary.
    set_wr(1'b0, 5'd0, 32'hDEAD_BEEF); step();
    set_wr(1'b1, 5'd0, 32'h3F80_0000); step();
    set_rd(1'b0, 5'd0, 1'b1, 5'd0); step();
    check("gpr0", operand_a, 32'h0);
    check("fpr0", operand_b, 32'h3F80_0000);

    // Same-edge bypass into FPR7 read only.
    set_wr(1'b0, 5'd7, 32'h11); step();
    set_wr(1'b1, 5'd7, 32'h4000_0000); set_rd(1'b1, 5'd7, 1'b0, 5'd7); step();
    check("byp_fpr7", operand_a, 32'h4000_0000);
    check("iso_gpr7", operand_b, 32'h11);

    // GPR0 bypass stays zero; both ports bypass the same register.
    set_wr(1'b0, 5'd0, 32'hCAFE_F00D); set_rd(1'b0, 5'd0, 1'b1, 5'd0); step();
    check("byp_gpr0", operand_a, 32'h0);
    set_wr(1'b0, 5'd2, 32'hA5A5_5A5A); set_rd(1'b0, 5'd2, 1'b0, 5'd2); step();
    check("byp_both_a", operand_a, 32'hA5A5_5A5A);
    check("byp_both_b", operand_b, 32'hA5A5_5A5A);

    // Condition code alongside a GPR write.
    set_wr(1'b0, 5'd9, 32'h5); cc_we = 1'b1; cc_in = 1'b1; step();
    check("cc_set", {31'd0, fp_cc_q}, 32'd1);
    set_rd(1'b0, 5'd9, 1'b0, 5'd3); step();
    check("gpr9", operand_a, 32'h5);
    cc_we = 1'b1; cc_in = 1'b0; step();
    check("cc_clr", {31'd0, fp_cc_q}, 32'd0);

    // Reset dropping an in-flight read.
    set_wr(1'b0, 5'd4, 32'h1234); step();
    set_rd(1'b0, 5'd4, 1'b0, 5'd4); rst = 1'b1; step();
    check("rst_drop", {31'd0, rd_valid}, 32'd0);
    set_rd(1'b0, 5'd4, 1'b0, 5'd3); step();
    check("gpr4_rst", operand_a, 32'h0);

    // Back-to-back reads.
    valid_run = 0;
    for (int i = 0; i < 4; i++) begin
      set_rd(1'b0, 5'(i), 1'b1, 5'(i)); step();
    end
    check("b2b_run", valid_run, 32'd4);

    // Randomised traffic over a small index range to provoke bypass hits.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) rst = 1'b1;
      rd_req   = 1'($urandom_range(0, 1));
      ra_float = 1'($urandom_range(0, 1));
      ra_addr  = 5'($urandom_range(0, 7));
      rb_float = 1'($urandom_range(0, 1));
      rb_addr  = 5'($urandom_range(0, 7));
      wr_en    = 1'($urandom_range(0, 1));
      wr_float = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      cc_we    = 1'($urandom_range(0, 1));
      cc_in    = 1'($urandom_range(0, 1));
      step();
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_regfile.md
Name: operand_regfile

Overview:
- Dual-bank architectural register file for the mini-MIPS datapath: 32 integer GPRs, 32 single-precision FPRs and the FP condition-code flag.
- Sits directly upstream of the ALU and feeds its a/b operands.
- Its write port takes the ALU result, selected by is_float, and the ALU fp_cc output at writeback.
- Registered reads with write-through bypass, so a result written in cycle N reaches the ALU operand in cycle N+1.

Parameters:
- DATA_W, 32, register width; must match the ALU operand width.
- NUM_REGS, 32, registers per bank; address width is clog2(NUM_REGS).
- ADDR_W, 5, address width (derived, overridable only consistently with NUM_REGS).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rd_req  input  1  read request; samples both read addresses this cycle
- ra_addr  input  ADDR_W  port A register index
- ra_float  input  1  port A bank select: 0=GPR, 1=FPR
- rb_addr  input  ADDR_W  port B register index
- rb_float  input  1  port B bank select
- rd_valid  output  1  operand_a/operand_b hold data for the request of the previous cycle
- operand_a  output  DATA_W  port A data, to ALU a
- operand_b  output  DATA_W  port B data, to ALU b
- wr_en  input  1  write enable
- wr_float  input  1  write bank select, driven from ALU is_float
- wr_addr  input  ADDR_W  write index
- wr_data  input  DATA_W  write data, driven from ALU result
- cc_we  input  1  FP condition-code write enable
- cc_in  input  1  driven from ALU fp_cc
- fp_cc_q  output  1  current FP condition-code flag, for branch logic

Behaviour:
- Reset (rst=1 at a rising edge) takes effect at that edge:
  - all 64 registers clear to 0, fp_cc_q to 0, rd_valid to 0, operand_a and operand_b to 0.
  - wr_en, cc_we and rd_req are ignored in any cycle with rst=1.
  - Reset asserted mid-read drops that read: rd_valid is 0 on the following cycle.
- Read latency is exactly 1 cycle. If rd_req=1 at edge N, then in cycle N+1 rd_valid=1 and the operands show the addressed contents.
- If rd_req=0 at edge N, rd_valid=0 in cycle N+1 and the operands hold their previous values. They are not cleared.
- Writes: if wr_en=1 at an edge, bank[wr_float][wr_addr] <= wr_data.
- GPR index 0 is hardwired zero:
  - writes with wr_float=0 and wr_addr=0 are discarded.
  - reads of GPR0 return 0.
  - FPR index 0 is an ordinary register.
- Bypass: on the same edge as a read, a port whose (bank, addr) equals the (wr_float, wr_addr) of an active write captures wr_data, not the old contents.
  - Exception: GPR0 bypass still yields 0.
  - Bypass applies independently to ports A and B.
  - Both ports may address the same register.
- Bank isolation: GPR k and FPR k are distinct storage. A write to one bank never bypasses into a read of the other bank.
- fp_cc: if cc_we=1 at an edge, fp_cc_q <= cc_in, visible the next cycle. cc_we and wr_en are independent and may both be active in the same cycle.
- Out-of-range addresses cannot occur when NUM_REGS=2^ADDR_W. Otherwise writes to index >= NUM_REGS are dropped and reads return 0.
- No back-pressure: every request is serviced. rd_req may be held high every cycle for back-to-back reads.

Test Plan:
- Reset, then read GPR5 and FPR5 -> rd_valid=1 one cycle after rd_req; both operands 0; fp_cc_q=0.
- Write GPR3=0x0000_00FF, then next cycle read A=GPR3 and B=FPR3 -> operand_a=0x0000_00FF, operand_b=0.
- Write GPR0=0xDEAD_BEEF and FPR0=0x3F80_0000, then read A=GPR0 and B=FPR0 -> operand_a=0, operand_b=0x3F80_0000.
- Same-edge bypass: write FPR7=0x4000_0000 while rd_req reads A=FPR7 and B=GPR7 (GPR7 holds 0x11) -> next cycle operand_a=0x4000_0000, operand_b=0x11.
- cc_we=1, cc_in=1 together with wr_en to GPR9=0x5 -> fp_cc_q=1 next cycle; a later read of GPR9 returns 0x5. Then cc_we=1, cc_in=0 -> fp_cc_q=0.
- Mid-operation reset:
  - Assert rd_req and rst in the same cycle after writing GPR4=0x1234 -> rd_valid=0 next cycle.
  - A subsequent read of GPR4 returns 0.
  - Back-to-back rd_req over 4 cycles keeps rd_valid high 4 consecutive cycles.
